// File: rtl/paddle_motion_pkg.sv
// paddle_motion_pkg: shared pong playfield geometry and paddle motion defaults.
// The draw stage imports the same constants, so both blocks agree on where the
// paddle may sit.
package paddle_motion_pkg;

   localparam int GAME_HEIGHT     = 272;
   localparam int GAME_WIDTH      = 480;
   localparam int PADDLE_HEIGHT   = 100;
   localparam int PADDLE_WIDTH    = 8;
   localparam int CORR_X          = 43;
   localparam int CORR_Y          = 12;
   localparam int STEP            = 4;
   localparam int DEBOUNCE_CYCLES = 50000;
   localparam int DB_CNT_W        = 16;

   // Position register and motion arithmetic width (one bit wider than paddle_Y).
   localparam int POS_W = 10;

   function automatic int y_min(input int corr_y);
      return corr_y;
   endfunction

   function automatic int y_max(input int corr_y, input int game_h, input int paddle_h);
      return corr_y + game_h - paddle_h;
   endfunction

   function automatic int y_center(input int corr_y, input int game_h, input int paddle_h);
      return game_h / 2 - paddle_h / 2 + corr_y;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser followed by a counting debouncer.
// Ports:
//   clk    in  clock
//   nrst   in  synchronous active-high reset
//   btn    in  raw asynchronous button
//   level  out debounced button level
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronised
// samples that differ from the current level; any agreeing sample restarts the count.
module btn_debounce
   import paddle_motion_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = paddle_motion_pkg::DEBOUNCE_CYCLES,
   parameter int DB_CNT_W        = paddle_motion_pkg::DB_CNT_W
) (
   input  logic clk,
   input  logic nrst,
   input  logic btn,
   output logic level
);

   localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                sync1;
   logic                sync2;
   logic [DB_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (nrst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/paddle_motion.sv
// paddle_motion: turns raw up/down buttons into the registered paddle top row.
// Ports:
//   clk         in  pixel/system clock
//   nrst        in  synchronous active-high reset
//   up_btn      in  raw up button (async, active-high)
//   down_btn    in  raw down button (async, active-high)
//   frame_tick  in  one-clk pulse per frame, during vertical blanking
//   move_en     in  game running; motion allowed
//   paddle_Y    out paddle top row, always within [Y_MIN, Y_MAX]
//   at_top      out paddle_Y == Y_MIN
//   at_bottom   out paddle_Y == Y_MAX
//   up_db       out debounced up level
//   down_db     out debounced down level
// paddle_Y moves at most once per frame, so it is stable while a frame is drawn.
module paddle_motion
   import paddle_motion_pkg::*;
#(
   parameter int PADDLE_HEIGHT   = paddle_motion_pkg::PADDLE_HEIGHT,
   parameter int GAME_HEIGHT     = paddle_motion_pkg::GAME_HEIGHT,
   parameter int CORR_Y          = paddle_motion_pkg::CORR_Y,
   parameter int STEP            = paddle_motion_pkg::STEP,
   parameter int DEBOUNCE_CYCLES = paddle_motion_pkg::DEBOUNCE_CYCLES,
   parameter int DB_CNT_W        = paddle_motion_pkg::DB_CNT_W
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       up_btn,
   input  logic       down_btn,
   input  logic       frame_tick,
   input  logic       move_en,
   output logic [8:0] paddle_Y,
   output logic       at_top,
   output logic       at_bottom,
   output logic       up_db,
   output logic       down_db
);

   localparam logic [POS_W-1:0] Y_MIN    = POS_W'(y_min(CORR_Y));
   localparam logic [POS_W-1:0] Y_MAX    = POS_W'(y_max(CORR_Y, GAME_HEIGHT, PADDLE_HEIGHT));
   localparam logic [POS_W-1:0] Y_CENTER = POS_W'(y_center(CORR_Y, GAME_HEIGHT, PADDLE_HEIGHT));
   localparam logic [POS_W-1:0] STEP_W   = POS_W'(STEP);

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_up_db (
      .clk   (clk),
      .nrst  (nrst),
      .btn   (up_btn),
      .level (up_db)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_CNT_W(DB_CNT_W)) u_down_db (
      .clk   (clk),
      .nrst  (nrst),
      .btn   (down_btn),
      .level (down_db)
   );

   logic [POS_W-1:0] y_ext;
   logic [8:0]       y_next;

   // Bounds are compared before the add/subtract so the 10-bit result never
   // wraps; a partial final step lands exactly on the limit.
   always_comb begin
      y_ext  = {1'b0, paddle_Y};
      y_next = paddle_Y;
      if (up_db && !down_db) begin
         if (y_ext < Y_MIN + STEP_W) y_next = 9'(Y_MIN);
         else                        y_next = 9'(y_ext - STEP_W);
      end else if (down_db && !up_db) begin
         if (y_ext > Y_MAX - STEP_W) y_next = 9'(Y_MAX);
         else                        y_next = 9'(y_ext + STEP_W);
      end
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         paddle_Y  <= 9'(Y_CENTER);
         at_top    <= 1'b0;
         at_bottom <= 1'b0;
      end else if (frame_tick && move_en) begin
         paddle_Y  <= y_next;
         at_top    <= ({1'b0, y_next} == Y_MIN);
         at_bottom <= ({1'b0, y_next} == Y_MAX);
      end
   end

endmodule

// File: tb/tb_paddle_motion.sv
// tb_paddle_motion: directed scenarios plus a random phase. A reference model
// pushes the expected outputs for every clock into a scoreboard queue and a
// monitor on the falling edge pops and compares them.
module tb_paddle_motion;

   localparam int DC       = 4;
   localparam int STEP     = 4;
   localparam int Y_MIN    = 12;
   localparam int Y_MAX    = 184;
   localparam int Y_CENTER = 98;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       up_btn = 1'b0;
   logic       down_btn = 1'b0;
   logic       frame_tick = 1'b0;
   logic       move_en = 1'b0;
   logic [8:0] paddle_Y;
   logic       at_top, at_bottom, up_db, down_db;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int y;
      bit top;
      bit bot;
      bit udb;
      bit ddb;
   } exp_t;

   exp_t sbq[$];

   paddle_motion #(.DEBOUNCE_CYCLES(DC), .DB_CNT_W(16)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .up_btn     (up_btn),
      .down_btn   (down_btn),
      .frame_tick (frame_tick),
      .move_en    (move_en),
      .paddle_Y   (paddle_Y),
      .at_top     (at_top),
      .at_bottom  (at_bottom),
      .up_db      (up_db),
      .down_db    (down_db)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Debounced level flips once the DC raw samples seen through the two sync
   // stages (raw from 2..2+DC-1 edges ago) all disagree with the current level.
   function automatic bit settle(input bit h[8], input bit db);
      for (int i = 2; i < 2 + DC; i++)
         if (h[i] == db) return db;
      return !db;
   endfunction

   // Reference model
   bit started = 0;
   int ym;
   bit um, dm;
   bit hu[8];
   bit hd[8];

   always @(posedge clk) begin
      exp_t e;
      if (nrst) begin
         started = 1;
         ym = Y_CENTER;
         um = 0;
         dm = 0;
         for (int i = 0; i < 8; i++) begin hu[i] = 0; hd[i] = 0; end
      end else if (started) begin
         for (int i = 7; i > 0; i--) begin hu[i] = hu[i-1]; hd[i] = hd[i-1]; end
         hu[0] = up_btn;
         hd[0] = down_btn;
         if (frame_tick && move_en) begin
            if (um && !dm)      ym = (ym - STEP < Y_MIN) ? Y_MIN : ym - STEP;
            else if (dm && !um) ym = (ym + STEP > Y_MAX) ? Y_MAX : ym + STEP;
         end
         um = settle(hu, um);
         dm = settle(hd, dm);
      end
      if (started) begin
         e = '{ym, ym == Y_MIN, ym == Y_MAX, um, dm};
         sbq.push_back(e);
      end
   end

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("sb_paddle_Y", paddle_Y, e.y);
         check("sb_at_top", at_top, e.top);
         check("sb_at_bottom", at_bottom, e.bot);
         check("sb_up_db", up_db, e.udb);
         check("sb_down_db", down_db, e.ddb);
         checks++;
         if (!(paddle_Y >= Y_MIN && paddle_Y <= Y_MAX) || (at_top && at_bottom)) begin
            errors++;
            $display("FAIL range: paddle_Y=%0d top=%0b bottom=%0b", paddle_Y, at_top, at_bottom);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc($urandom_range(0, 3));
   endtask

   task automatic do_reset();
      nrst = 1'b1;
      cyc(1);
      nrst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      // Reset
      nrst = 1'b1;
      cyc(2);
      nrst = 1'b0;
      check("reset_y", paddle_Y, Y_CENTER);
      check("reset_top", at_top, 0);
      check("reset_bottom", at_bottom, 0);
      check("reset_db", {up_db, down_db}, 0);

      // Stepping down
      move_en = 1'b1;
      down_btn = 1'b1;
      cyc(DC + 3);
      check("down_db_set", down_db, 1);
      repeat (10) tick();
      check("step_y", paddle_Y, 138);

      // Bottom clamp
      repeat (30) tick();
      check("clamp_bot_y", paddle_Y, Y_MAX);
      check("clamp_bot_flag", at_bottom, 1);

      // Glitch on up is filtered
      down_btn = 1'b0;
      cyc(DC + 3);
      up_btn = 1'b1;
      cyc(3);
      up_btn = 1'b0;
      cyc(10);
      check("glitch_up_db", up_db, 0);
      tick();
      check("glitch_y", paddle_Y, Y_MAX);

      // Both held: hold
      up_btn = 1'b1;
      down_btn = 1'b1;
      cyc(DC + 3);
      check("both_db", {up_db, down_db}, 2'b11);
      repeat (3) tick();
      check("both_y", paddle_Y, Y_MAX);
      up_btn = 1'b0;
      down_btn = 1'b0;
      cyc(DC + 3);

      // Top clamp with a partial step
      do_reset();
      check("reset2_y", paddle_Y, Y_CENTER);
      up_btn = 1'b1;
      cyc(DC + 3);
      repeat (21) tick();
      check("near_top_y", paddle_Y, 14);
      check("near_top_flag", at_top, 0);
      tick();
      check("clamp_top_y", paddle_Y, Y_MIN);
      check("clamp_top_flag", at_top, 1);
      tick();
      check("clamp_top_hold", paddle_Y, Y_MIN);
      up_btn = 1'b0;
      cyc(DC + 3);

      // Gating: ticks without move_en, move_en without ticks
      move_en = 1'b0;
      down_btn = 1'b1;
      cyc(DC + 3);
      repeat (5) tick();
      check("gate_tick_y", paddle_Y, Y_MIN);
      move_en = 1'b1;
      cyc(10);
      check("gate_en_y", paddle_Y, Y_MIN);

      // Reset mid-motion at Y=150
      do_reset();
      cyc(DC + 3);
      repeat (13) tick();
      check("pre_reset_y", paddle_Y, 150);
      frame_tick = 1'b1;
      nrst = 1'b1;
      cyc(1);
      nrst = 1'b0;
      frame_tick = 1'b0;
      check("mid_reset_y", paddle_Y, Y_CENTER);
      check("mid_reset_db", {up_db, down_db}, 0);
      down_btn = 1'b0;

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) up_btn = ~up_btn;
         if ($urandom_range(0, 24) == 0) down_btn = ~down_btn;
         frame_tick = ($urandom_range(0, 5) == 0);
         move_en = ($urandom_range(0, 7) != 0);
         nrst = ($urandom_range(0, 599) == 0);
         cyc(1);
      end
      nrst = 1'b0;
      frame_tick = 1'b0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
